// File: rtl/router_input_buffer_if.sv
// rtl/router_input_buffer_if.sv - flit handshake bundle between upstream link, input FIFO and consumer
interface router_input_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  ready_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  read_en;
   logic                  overflow;
   logic                  underflow;

   modport slave (
      input  data_in,
      input  valid_in,
      input  read_en,
      output ready_out,
      output data_out,
      output valid_out,
      output overflow,
      output underflow
   );

   modport master (
      output data_in,
      output valid_in,
      output read_en,
      input  ready_out,
      input  data_out,
      input  valid_out,
      input  overflow,
      input  underflow
   );
endinterface

// File: rtl/router_input_buffer.sv
// rtl/router_input_buffer.sv - per-port FWFT input FIFO with registered, margin-based ready
module router_input_buffer #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int READY_MARGIN = 1
) (
   input logic                  clk,
   input logic                  rst,
   router_input_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_ready;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic [CNT_W-1:0]      w_count_next;
   logic [CNT_W-1:0]      w_free_next;

   // A full FIFO still accepts a write when the head is popped on the same edge.
   always_comb begin
      w_rd_ok      = bus.read_en && (r_count != '0);
      w_wr_ok      = bus.valid_in && ((r_count != CNT_W'(DEPTH)) || w_rd_ok);
      w_count_next = r_count;
      if (w_wr_ok && !w_rd_ok) begin
         w_count_next = r_count + CNT_W'(1);
      end else if (!w_wr_ok && w_rd_ok) begin
         w_count_next = r_count - CNT_W'(1);
      end
      w_free_next  = CNT_W'(DEPTH) - w_count_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ready     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_next;
         // Margin leaves room for a flit already in flight on a stale ready.
         r_ready <= (w_free_next > CNT_W'(READY_MARGIN));
         if (bus.valid_in && !w_wr_ok) begin
            r_overflow <= 1'b1;
         end
         if (bus.read_en && (r_count == '0)) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) begin
         r_mem[r_wr_ptr] <= bus.data_in;
      end
   end

   assign bus.ready_out = r_ready;
   assign bus.valid_out = (r_count != '0);
   assign bus.data_out  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_router_input_buffer.sv
// tb/tb_router_input_buffer.sv - directed table plus randomized queue-model bench for router_input_buffer
module tb_router_input_buffer;
   localparam int DW     = 32;
   localparam int DEPTH  = 4;
   localparam int MARGIN = 1;

   typedef struct {
      logic          rs;
      logic          v;
      logic [DW-1:0] d;
      logic          r;
      logic          ev;
      logic [DW-1:0] ed;
      logic          er;
      logic          eo;
      logic          eu;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [DW-1:0] mq[$];
   logic          m_ovf;
   logic          m_unf;
   logic          m_rdy;
   vec_t          tbl[$];

   router_input_buffer_if #(.DATA_WIDTH(DW)) bus ();

   router_input_buffer #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .READY_MARGIN(MARGIN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rs, input logic v, input logic [DW-1:0] d, input logic r,
                      input logic ev, input logic [DW-1:0] ed, input logic er,
                      input logic eo, input logic eu);
      vec_t t;
      t.rs = rs; t.v = v; t.d = d; t.r = r;
      t.ev = ev; t.ed = ed; t.er = er; t.eo = eo; t.eu = eu;
      tbl.push_back(t);
   endtask

   // Queue model: pop the head, then append the accepted flit.
   task automatic step(input logic rs, input logic v, input logic [DW-1:0] d, input logic r);
      int n;
      bit pop;
      bit acc;
      rst          = rs;
      bus.valid_in = v;
      bus.data_in  = d;
      bus.read_en  = r;
      @(posedge clk);
      if (rs) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rdy = 1'b0;
      end else begin
         n   = mq.size();
         pop = r && (n > 0);
         acc = v && ((n < DEPTH) || pop);
         if (r && n == 0) m_unf = 1'b1;
         if (v && !acc) m_ovf = 1'b1;
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(d);
         m_rdy = ((DEPTH - mq.size()) > MARGIN);
      end
      #1;
      chk("model_valid_out", {31'd0, bus.valid_out}, {31'd0, mq.size() != 0});
      chk("model_data_out", bus.data_out, (mq.size() != 0) ? mq[0] : '0);
      chk("model_ready_out", {31'd0, bus.ready_out}, {31'd0, m_rdy});
      chk("model_overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      chk("model_underflow", {31'd0, bus.underflow}, {31'd0, m_unf});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rdy = 1'b0;
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.read_en  = 1'b0;

      // reset held with traffic, then release
      add(1, 1, 32'hFF, 0,  0, 32'h0, 0, 0, 0);
      add(1, 1, 32'hFF, 0,  0, 32'h0, 0, 0, 0);
      add(1, 1, 32'hFF, 0,  0, 32'h0, 0, 0, 0);
      add(0, 0, 32'h0,  0,  0, 32'h0, 1, 0, 0);
      // threshold and overflow
      add(0, 1, 32'hA1, 0,  1, 32'hA1, 1, 0, 0);
      add(0, 1, 32'hA2, 0,  1, 32'hA1, 1, 0, 0);
      add(0, 1, 32'hA3, 0,  1, 32'hA1, 0, 0, 0);
      add(0, 1, 32'hA4, 0,  1, 32'hA1, 0, 0, 0);
      add(0, 1, 32'hA5, 0,  1, 32'hA1, 0, 1, 0);
      add(0, 0, 32'h0,  1,  1, 32'hA2, 0, 1, 0);
      add(0, 0, 32'h0,  1,  1, 32'hA3, 1, 1, 0);
      add(0, 0, 32'h0,  1,  1, 32'hA4, 1, 1, 0);
      add(0, 0, 32'h0,  1,  0, 32'h0,  1, 1, 0);
      // full with simultaneous push/pop
      add(1, 0, 32'h0,  0,  0, 32'h0,  0, 0, 0);
      add(0, 0, 32'h0,  0,  0, 32'h0,  1, 0, 0);
      add(0, 1, 32'hB1, 0,  1, 32'hB1, 1, 0, 0);
      add(0, 1, 32'hB2, 0,  1, 32'hB1, 1, 0, 0);
      add(0, 1, 32'hB3, 0,  1, 32'hB1, 0, 0, 0);
      add(0, 1, 32'hB4, 0,  1, 32'hB1, 0, 0, 0);
      add(0, 1, 32'hB5, 1,  1, 32'hB2, 0, 0, 0);
      add(0, 0, 32'h0,  1,  1, 32'hB3, 0, 0, 0);
      add(0, 0, 32'h0,  1,  1, 32'hB4, 1, 0, 0);
      add(0, 0, 32'h0,  1,  1, 32'hB5, 1, 0, 0);
      add(0, 0, 32'h0,  1,  0, 32'h0,  1, 0, 0);
      // empty read, then read with same-cycle write
      add(0, 0, 32'h0,  1,  0, 32'h0,  1, 0, 1);
      add(0, 1, 32'hC1, 1,  1, 32'hC1, 1, 0, 1);
      add(0, 0, 32'h0,  1,  0, 32'h0,  1, 0, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rs, tbl[i].v, tbl[i].d, tbl[i].r);
         chk($sformatf("tbl%0d_valid", i), {31'd0, bus.valid_out}, {31'd0, tbl[i].ev});
         chk($sformatf("tbl%0d_data", i), bus.data_out, tbl[i].ed);
         chk($sformatf("tbl%0d_ready", i), {31'd0, bus.ready_out}, {31'd0, tbl[i].er});
         chk($sformatf("tbl%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, tbl[i].eo});
         chk($sformatf("tbl%0d_unf", i), {31'd0, bus.underflow}, {31'd0, tbl[i].eu});
      end

      // wrap-around: steady one-in/one-out keeps a single flit resident
      step(0, 1, 32'h00, 0);
      for (int i = 1; i < 12; i++) begin
         step(0, 1, DW'(i), 1);
         chk($sformatf("wrap%0d_data", i), bus.data_out, DW'(i));
         chk($sformatf("wrap%0d_valid", i), {31'd0, bus.valid_out}, 32'd1);
         chk($sformatf("wrap%0d_ready", i), {31'd0, bus.ready_out}, 32'd1);
      end
      step(0, 0, 32'h0, 1);
      chk("wrap_drained", {31'd0, bus.valid_out}, 32'd0);

      // reset in the middle of traffic
      step(0, 1, 32'h11, 0);
      step(0, 1, 32'h12, 0);
      step(0, 1, 32'h13, 0);
      chk("midrst_pre_unf", {31'd0, bus.underflow}, 32'd1);
      step(1, 1, 32'hEE, 1);
      chk("midrst_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("midrst_unf", {31'd0, bus.underflow}, 32'd0);
      chk("midrst_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("midrst_ready0", {31'd0, bus.ready_out}, 32'd0);
      step(0, 0, 32'h0, 0);
      chk("midrst_ready1", {31'd0, bus.ready_out}, 32'd1);
      chk("midrst_empty", {31'd0, bus.valid_out}, 32'd0);
      step(0, 1, 32'hD1, 0);
      chk("midrst_head", bus.data_out, 32'hD1);

      // randomized traffic against the queue model
      step(1, 0, 32'h0, 0);
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 59) == 0,
              $urandom_range(0, 99) < 60,
              $urandom,
              $urandom_range(0, 99) < 50);
      end

      rst = 1'b0;
      bus.valid_in = 1'b0;
      bus.read_en  = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
